nurn_rcl_ctrlr: RTL

- Parametrised recall-phase controller for a time-multiplexed neuron core: sequences weight, bias, membrane-potential, leak and threshold accumulation for every neuron, then writes the results back to status memory.
- Generalises the 2-type recall FSM: derived counter widths, 3 neuron types (adds leaky I&F), sparse axon skipping, start/busy/done handshake, per-neuron learn request to a separate learning controller.
- Sits between the time-step scheduler (start/done) and the neuron datapath/memories.

---
 rtl/nurn_ctrl_pkg.sv | 48 ++++
 rtl/nurn_cntr.sv | 37 +++
 rtl/nurn_rcl_ctrlr.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/nurn_ctrl_pkg.sv
// Shared encodings for the neuron-core recall controller: FSM states,
// adder/write-back select codes, status word offsets and neuron types.
package nurn_ctrl_pkg;

  typedef enum logic [7:0] {
    S_IDLE     = 8'b0000_0001,
    S_ACC_WT   = 8'b0000_0010,
    S_ACC_BIAS = 8'b0000_0100,
    S_ACC_MEMB = 8'b0000_1000,
    S_LEAK     = 8'b0001_0000,
    S_THRESH   = 8'b0010_0000,
    S_WR_BACK  = 8'b0100_0000,
    S_DRAIN    = 8'b1000_0000
  } rclState_e;

  localparam logic [2:0] ADD_WT     = 3'd0;
  localparam logic [2:0] ADD_BIAS   = 3'd1;
  localparam logic [2:0] ADD_MEMB   = 3'd2;
  localparam logic [2:0] ADD_NEG_TH = 3'd3;
  localparam logic [2:0] ADD_LEAK   = 3'd4;

  localparam logic [1:0] WB_BIAS   = 2'd0;
  localparam logic [1:0] WB_MEMB   = 2'd1;
  localparam logic [1:0] WB_THRESH = 2'd2;

  localparam logic [1:0] OFF_BIAS   = 2'b00;
  localparam logic [1:0] OFF_MEMB   = 2'b01;
  localparam logic [1:0] OFF_THRESH = 2'b10;
  localparam logic [1:0] OFF_LEAK   = 2'b11;

  typedef enum logic [1:0] {
    NT_IF   = 2'd0,
    NT_RELU = 2'd1,
    NT_LIF  = 2'd2,
    NT_RSVD = 2'd3
  } nurnType_e;

  // Status word read by each status-accumulate state.
  function automatic logic [1:0] statOff(rclState_e s);
    case (s)
      S_ACC_MEMB: return OFF_MEMB;
      S_LEAK:     return OFF_LEAK;
      S_THRESH:   return OFF_THRESH;
      default:    return OFF_BIAS;
    endcase
  endfunction

endpackage

// File: rtl/nurn_cntr.sv
// Saturating up-counter with clear and enable; exposes its next value so the
// controller can register addresses for the cycle in which they are used.
module nurn_cntr #(
  parameter int unsigned W    = 2,
  parameter int unsigned TERM = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cntNxt_c,
  output logic         done_c
);

  localparam logic [W-1:0] TermV = W'(TERM);

  always_comb begin
    cntNxt_c = cnt;
    if (clr) begin
      cntNxt_c = '0;
    end else if (en && (cnt != TermV)) begin
      cntNxt_c = cnt + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else begin
      cnt <= cntNxt_c;
    end
  end

  assign done_c = (cnt == TermV);

endmodule

// File: rtl/nurn_rcl_ctrlr.sv
// Recall-phase controller: walks every neuron through weight, bias, membrane,
// leak and threshold accumulation, then writes the membrane potential back.
module nurn_rcl_ctrlr
  import nurn_ctrl_pkg::*;
#(
  parameter int unsigned NUM_NURNS  = 4,
  parameter int unsigned NUM_AXONS  = 4,
  parameter int unsigned NURN_W     = $clog2(NUM_NURNS),
  parameter int unsigned AXON_W     = $clog2(NUM_AXONS),
  parameter bit          SKIP_EMPTY = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  input  logic [NUM_AXONS-1:0]     spkVld_i,
  input  logic [1:0]               NurnType_i,
  output logic                     rdEn_Config_o,
  output logic [NURN_W-1:0]        Addr_Config_o,
  output logic                     rdEn_Wt_o,
  output logic [NURN_W+AXON_W-1:0] Addr_Wt_o,
  output logic                     rdEn_StatRd_A_o,
  output logic [NURN_W+1:0]        Addr_StatRd_A_o,
  output logic                     wrEn_StatWr_B_o,
  output logic [NURN_W+1:0]        Addr_StatWr_B_o,
  output logic [1:0]               sel_wrBackStat_B_o,
  output logic                     rstAcc_o,
  output logic                     accEn_o,
  output logic                     cmp_th_o,
  output logic                     buffMembPot_o,
  output logic [2:0]               sel_rclAdd_B_o,
  output logic                     lrnReq_o,
  output logic [NURN_W-1:0]        lrnNurn_o
);

  rclState_e         state, stNxt;
  logic [NURN_W-1:0] nurn, nurnNxt;
  logic [AXON_W-1:0] axon, axonNxt;
  logic              nurnDone, nurnClr, nurnEn;
  logic              axonDone, axonClr, axonEn;
  logic              spkEmpty, isLif, isRelu, firstSt;

  assign spkEmpty = SKIP_EMPTY && (spkVld_i == '0);
  assign isLif    = (NurnType_i == NT_LIF);
  assign isRelu   = (NurnType_i == NT_RELU);

  nurn_cntr #(.W(NURN_W), .TERM(NUM_NURNS - 1)) uNurnCntr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (nurnClr),
    .en       (nurnEn),
    .cnt      (nurn),
    .cntNxt_c (nurnNxt),
    .done_c   (nurnDone)
  );

  nurn_cntr #(.W(AXON_W), .TERM(NUM_AXONS - 1)) uAxonCntr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (axonClr),
    .en       (axonEn),
    .cnt      (axon),
    .cntNxt_c (axonNxt),
    .done_c   (axonDone)
  );

  // Next state and counter control.
  always_comb begin
    stNxt   = state;
    nurnClr = 1'b0;
    nurnEn  = 1'b0;
    axonClr = 1'b0;
    axonEn  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          stNxt   = spkEmpty ? S_ACC_BIAS : S_ACC_WT;
          nurnClr = 1'b1;
          axonClr = 1'b1;
        end
      end
      S_ACC_WT: begin
        if (axonDone) stNxt = S_ACC_BIAS;
        else          axonEn = 1'b1;
      end
      S_ACC_BIAS: stNxt = S_ACC_MEMB;
      S_ACC_MEMB: stNxt = isLif ? S_LEAK : S_THRESH;
      S_LEAK:     stNxt = S_THRESH;
      S_THRESH:   stNxt = S_WR_BACK;
      S_WR_BACK: begin
        if (nurnDone) begin
          stNxt = S_DRAIN;
        end else begin
          stNxt   = spkEmpty ? S_ACC_BIAS : S_ACC_WT;
          nurnEn  = 1'b1;
          axonClr = 1'b1;
        end
      end
      S_DRAIN: stNxt = S_IDLE;
      default: stNxt = S_IDLE;
    endcase
  end

  // A new neuron begins: its type is fetched so it is valid by ACC_MEMB.
  assign firstSt = ((state == S_IDLE) || (state == S_WR_BACK)) &&
                   ((stNxt == S_ACC_WT) || (stNxt == S_ACC_BIAS));

  assign rstAcc_o = !rst_i && (((state == S_IDLE) && start_i) ||
                               ((state == S_WR_BACK) && !nurnDone));

  // Read strobes are set for the state being entered; accumulate strobes
  // follow the state that issued the read, matching the memory latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state              <= S_IDLE;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      rdEn_Config_o      <= 1'b0;
      Addr_Config_o      <= '0;
      rdEn_Wt_o          <= 1'b0;
      Addr_Wt_o          <= '0;
      rdEn_StatRd_A_o    <= 1'b0;
      Addr_StatRd_A_o    <= '0;
      wrEn_StatWr_B_o    <= 1'b0;
      Addr_StatWr_B_o    <= '0;
      sel_wrBackStat_B_o <= WB_BIAS;
      accEn_o            <= 1'b0;
      cmp_th_o           <= 1'b0;
      buffMembPot_o      <= 1'b0;
      sel_rclAdd_B_o     <= ADD_WT;
      lrnReq_o           <= 1'b0;
      lrnNurn_o          <= '0;
    end else begin
      state         <= stNxt;
      busy_o        <= (stNxt != S_IDLE);
      done_o        <= (stNxt == S_DRAIN);
      rdEn_Config_o <= firstSt || (stNxt == S_ACC_MEMB);
      Addr_Config_o <= nurnNxt;

      rdEn_Wt_o <= 1'b0;
      if (stNxt == S_ACC_WT) begin
        rdEn_Wt_o <= spkVld_i[axonNxt];
        Addr_Wt_o <= {nurnNxt, axonNxt};
      end

      rdEn_StatRd_A_o <= 1'b0;
      if ((stNxt == S_ACC_BIAS) || (stNxt == S_ACC_MEMB) ||
          (stNxt == S_LEAK) || (stNxt == S_THRESH)) begin
        rdEn_StatRd_A_o <= 1'b1;
        Addr_StatRd_A_o <= {nurnNxt, statOff(stNxt)};
      end

      accEn_o        <= 1'b0;
      cmp_th_o       <= 1'b0;
      sel_rclAdd_B_o <= ADD_WT;
      case (state)
        S_ACC_WT:   accEn_o <= spkVld_i[axon];
        S_ACC_BIAS: begin accEn_o <= 1'b1; sel_rclAdd_B_o <= ADD_BIAS; end
        S_ACC_MEMB: begin accEn_o <= 1'b1; sel_rclAdd_B_o <= ADD_MEMB; end
        S_LEAK:     begin accEn_o <= 1'b1; sel_rclAdd_B_o <= ADD_LEAK; end
        S_THRESH: begin
          cmp_th_o <= 1'b1;
          if (isRelu) begin
            accEn_o        <= 1'b1;
            sel_rclAdd_B_o <= ADD_NEG_TH;
          end
        end
        default: ;
      endcase

      // Write-back targets the neuron just finished, latched before the counter moves.
      wrEn_StatWr_B_o <= (state == S_WR_BACK);
      buffMembPot_o   <= (state == S_WR_BACK);
      lrnReq_o        <= (state == S_WR_BACK);
      if (state == S_WR_BACK) begin
        Addr_StatWr_B_o    <= {nurn, OFF_MEMB};
        sel_wrBackStat_B_o <= WB_MEMB;
        lrnNurn_o          <= nurn;
      end
    end
  end

endmodule
